// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream program loader.
// Takes START_BYTE, CNT_HI, CNT_LO, N x (B0,B1,B2), CSUM from a valid/ready
// byte source and writes 18-bit words into program memory while holding the MCU.
// Optional build macro: LOADER_TIMEOUT_EN (inter-byte timeout, aborts to ERR).
//
// state  | meaning
// IDLE   | hunting for START_BYTE, other bytes discarded
// CNT_HI | expecting word-count high byte (bits [2:0] used)
// CNT_LO | expecting word-count low byte, range check 1..2**ADDR_WIDTH
// B0     | expecting word bits [17:16] (byte bits [1:0])
// B1     | expecting word bits [15:8]
// B2     | expecting word bits [7:0]
// WRITE  | one-cycle program-memory write, then next word or checksum
// CSUM   | expecting checksum byte
// DONE   | frame good, raise LOAD_OK, release MCU
// ERR    | frame bad, raise LOAD_ERR, release MCU

module prog_loader #(
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         ADDR_WIDTH     = 10,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  PROG_CLK,
  input  logic                  RESET,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  RX_READY,
  output logic                  PROG_WE,
  output logic [ADDR_WIDTH-1:0] PROG_WADDR,
  output logic [17:0]           PROG_WDATA,
  output logic                  MCU_HOLD,
  output logic                  LOAD_OK,
  output logic                  LOAD_ERR
);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CSUM, DONE, ERR
  } state_t;

  localparam logic [10:0] MAX_WORDS = 11'(1 << ADDR_WIDTH);

  state_t                state_q, state_d;
  logic                  rx_ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [17:0]           wdata_q;
  logic [7:0]            csum_q;
  logic [2:0]            cnt_hi_q;
  logic [10:0]           n_q;
  logic [10:0]           wcnt_q;
  logic [1:0]            b0_q;
  logic [7:0]            b1_q;
  logic                  hold_q, ok_q, err_q;

  logic        xfer;
  logic [10:0] count_w;
  logic        ready_d;

  assign xfer    = RX_VALID && rx_ready_q;
  assign count_w = {cnt_hi_q, RX_DATA};
  assign ready_d = !(state_d inside {WRITE, DONE, ERR});

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q;
  logic          waiting;

  assign waiting = state_q inside {CNT_HI, CNT_LO, B0, B1, B2, CSUM};

  // Inter-byte down-counter: reloads on every accepted byte and outside the waiting states.
  always_ff @(posedge PROG_CLK) begin
    if (RESET) begin
      tmo_q <= TMO_LOAD;
    end else if (xfer || !waiting) begin
      tmo_q <= TMO_LOAD;
    end else if (tmo_q != '0) begin
      tmo_q <= tmo_q - 1'b1;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

  // Next-state decode for the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (xfer && RX_DATA == START_BYTE) state_d = CNT_HI;
      CNT_HI: if (xfer) state_d = CNT_LO;
      CNT_LO: if (xfer) state_d = (count_w == 11'd0 || count_w > MAX_WORDS) ? ERR : B0;
      B0:     if (xfer) state_d = B1;
      B1:     if (xfer) state_d = B2;
      B2:     if (xfer) state_d = WRITE;
      WRITE:  state_d = (wcnt_q + 11'd1 == n_q) ? CSUM : B0;
      CSUM:   if (xfer) state_d = (RX_DATA == csum_q) ? DONE : ERR;
      DONE:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LOADER_TIMEOUT_EN
    if (waiting && !xfer && tmo_q == '0) state_d = ERR;
`endif
  end

  // State register, registered handshake/strobe, and frame datapath.
  always_ff @(posedge PROG_CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      csum_q     <= '0;
      cnt_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      hold_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= ready_d;
      we_q       <= (state_d == WRITE);
      case (state_q)
        IDLE: if (xfer && RX_DATA == START_BYTE) begin
          ok_q   <= 1'b0;
          err_q  <= 1'b0;
          hold_q <= 1'b1;
          addr_q <= '0;
          csum_q <= '0;
          wcnt_q <= '0;
        end
        CNT_HI: if (xfer) cnt_hi_q <= RX_DATA[2:0];
        CNT_LO: if (xfer) n_q <= count_w;
        B0: if (xfer) begin
          b0_q   <= RX_DATA[1:0];
          csum_q <= csum_q + RX_DATA;
        end
        B1: if (xfer) begin
          b1_q   <= RX_DATA;
          csum_q <= csum_q + RX_DATA;
        end
        B2: if (xfer) begin
          wdata_q <= {b0_q, b1_q, RX_DATA};
          csum_q  <= csum_q + RX_DATA;
        end
        WRITE: begin
          addr_q <= addr_q + 1'b1;
          wcnt_q <= wcnt_q + 11'd1;
        end
        DONE: begin
          ok_q   <= 1'b1;
          hold_q <= 1'b0;
        end
        ERR: begin
          err_q  <= 1'b1;
          hold_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Gating with RESET kills a write strobe already in flight when reset lands mid-WRITE.
  assign PROG_WE    = we_q && !RESET;
  assign RX_READY   = rx_ready_q;
  assign PROG_WADDR = addr_q;
  assign PROG_WDATA = wdata_q;
  assign MCU_HOLD   = hold_q;
  assign LOAD_OK    = ok_q;
  assign LOAD_ERR   = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by the stimulus,
// a monitor branch pops and compares on every PROG_WE seen at the falling edge.
module tb_prog_loader;

  logic        PROG_CLK = 1'b0;
  logic        RESET;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        PROG_WE;
  logic [9:0]  PROG_WADDR;
  logic [17:0] PROG_WDATA;
  logic        MCU_HOLD;
  logic        LOAD_OK;
  logic        LOAD_ERR;

  int checks = 0;
  int errors = 0;
  logic [27:0] exp_q[$];
  logic        stim_done = 1'b0;

  always #5 PROG_CLK = ~PROG_CLK;

  prog_loader #(.START_BYTE(8'hA5), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(16)) dut (
    .PROG_CLK(PROG_CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_READY(RX_READY), .PROG_WE(PROG_WE), .PROG_WADDR(PROG_WADDR),
    .PROG_WDATA(PROG_WDATA), .MCU_HOLD(MCU_HOLD), .LOAD_OK(LOAD_OK), .LOAD_ERR(LOAD_ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard = 0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    while (!RX_READY && guard < 100) begin
      @(posedge PROG_CLK); #1;
      guard++;
    end
    if (guard >= 100) chk("rx_ready_timeout", 32'(RX_READY), 32'd1);
    @(posedge PROG_CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PROG_CLK);
    #1;
  endtask

  task automatic push(input logic [9:0] a, input logic [17:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00;
    fork
      begin : monitor
        logic [27:0] e;
        forever begin
          @(negedge PROG_CLK);
          if (PROG_WE) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_write_addr", 32'(PROG_WADDR), 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              chk("write_addr", 32'(PROG_WADDR), 32'(e[27:18]));
              chk("write_data", 32'(PROG_WDATA), 32'(e[17:0]));
            end
          end
        end
      end
      begin : stimulus
        idle(2);
        chk("rst_rx_ready", 32'(RX_READY), 32'd0);
        chk("rst_prog_we",  32'(PROG_WE),  32'd0);
        chk("rst_waddr",    32'(PROG_WADDR), 32'd0);
        chk("rst_wdata",    32'(PROG_WDATA), 32'd0);
        chk("rst_hold",     32'(MCU_HOLD), 32'd0);
        chk("rst_ok",       32'(LOAD_OK),  32'd0);
        chk("rst_err",      32'(LOAD_ERR), 32'd0);
        RESET = 1'b0;
        idle(1);
        chk("idle_rx_ready", 32'(RX_READY), 32'd1);

        // Good two-word frame; checksum = 01+23+45+02+AB+CD mod 256 = E3.
        push(10'd0, 18'h12345);
        push(10'd1, 18'h2ABCD);
        send(8'hA5);
        chk("hold_after_start", 32'(MCU_HOLD), 32'd1);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h23); send(8'h45);
        send(8'h02); send(8'hAB); send(8'hCD);
        send(8'hE3);
        chk("hold_in_done", 32'(MCU_HOLD), 32'd1);
        idle(1);
        chk("good_ok",   32'(LOAD_OK),  32'd1);
        chk("good_err",  32'(LOAD_ERR), 32'd0);
        chk("good_hold", 32'(MCU_HOLD), 32'd0);

        // Same frame with a wrong checksum: words still written, frame fails.
        push(10'd0, 18'h12345);
        push(10'd1, 18'h2ABCD);
        send(8'hA5);
        chk("ok_cleared_on_start", 32'(LOAD_OK), 32'd0);
        send(8'h00); send(8'h02);
        send(8'h01); send(8'h23); send(8'h45);
        send(8'h02); send(8'hAB); send(8'hCD);
        send(8'hE4);
        idle(1);
        chk("bad_ok",   32'(LOAD_OK),  32'd0);
        chk("bad_err",  32'(LOAD_ERR), 32'd1);
        chk("bad_hold", 32'(MCU_HOLD), 32'd0);

        // Non-start bytes ignored in IDLE, then a zero word count aborts.
        send(8'h00); send(8'hFF);
        chk("idle_junk_hold", 32'(MCU_HOLD), 32'd0);
        chk("idle_junk_err_sticky", 32'(LOAD_ERR), 32'd1);
        send(8'hA5);
        chk("hold_after_start2", 32'(MCU_HOLD), 32'd1);
        chk("err_cleared_on_start", 32'(LOAD_ERR), 32'd0);
        send(8'h00); send(8'h00);
        idle(1);
        chk("zero_cnt_err",  32'(LOAD_ERR), 32'd1);
        chk("zero_cnt_hold", 32'(MCU_HOLD), 32'd0);
        chk("zero_cnt_ok",   32'(LOAD_OK),  32'd0);

        // Full 1024-word image of zeros; CNT_HI upper bits set to prove they are ignored.
        for (int i = 0; i < 1024; i++) push(10'(i), 18'h0);
        send(8'hA5); send(8'hFC); send(8'h00);
        for (int i = 0; i < 3072; i++) send(8'h00);
        send(8'h00);
        idle(1);
        chk("full_ok",   32'(LOAD_OK),  32'd1);
        chk("full_err",  32'(LOAD_ERR), 32'd0);
        chk("full_hold", 32'(MCU_HOLD), 32'd0);
        idle(5);
        chk("full_queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset landing on the second word's write cycle suppresses the write.
        push(10'd0, 18'h12345);
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h01); send(8'h23); send(8'h45);
        send(8'h02); send(8'hAB); send(8'hCD);
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        chk("mid_rst_rx_ready", 32'(RX_READY), 32'd0);
        chk("mid_rst_we",    32'(PROG_WE),    32'd0);
        chk("mid_rst_waddr", 32'(PROG_WADDR), 32'd0);
        chk("mid_rst_wdata", 32'(PROG_WDATA), 32'd0);
        chk("mid_rst_hold",  32'(MCU_HOLD),   32'd0);
        chk("mid_rst_ok",    32'(LOAD_OK),    32'd0);
        chk("mid_rst_err",   32'(LOAD_ERR),   32'd0);

        // Fresh one-word frame after reset: word {11,FF,A5}, A5 mid-frame is data.
        // Checksum 03+FF+A5 = 1A7 -> A7.
        push(10'd0, 18'h3FFA5);
        send(8'hA5); send(8'h00); send(8'h01);
        send(8'h03); send(8'hFF); send(8'hA5);
        send(8'hA7);
        idle(1);
        chk("reload_ok",  32'(LOAD_OK),  32'd1);
        chk("reload_err", 32'(LOAD_ERR), 32'd0);

        // Stall after the count-high byte.
        send(8'hA5); send(8'h00);
        idle(40);
`ifdef LOADER_TIMEOUT_EN
        chk("stall_err",  32'(LOAD_ERR), 32'd1);
        chk("stall_hold", 32'(MCU_HOLD), 32'd0);
`else
        chk("stall_err",   32'(LOAD_ERR), 32'd0);
        chk("stall_hold",  32'(MCU_HOLD), 32'd1);
        chk("stall_ready", 32'(RX_READY), 32'd1);
`endif
        do_reset();
        idle(3);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        stim_done = 1'b1;
      end
      begin : watchdog
        repeat (60000) @(posedge PROG_CLK);
        if (!stim_done) chk("global_timeout", 32'(stim_done), 32'd1);
      end
    join_any
    disable fork;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
